fp_result_buffer: RTL and testbench
===================================

# fp_result_buffer

Downstream stage of the sequential floating-point multiplier: captures each registered product (result plus overflow flag) on `slow_clk` into a small first-word-fall-through FIFO. It tags every entry with an IEEE-754 class code and presents entries to the consumer over a valid/ready handshake. It also keeps saturating statistics on overflowing products and on products dropped while the buffer was full.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, at least 2.
- `CNT_W`, 16: width of the statistics counters.

Ports:
- `slow_clk`  in  1: clock; the same slow clock that drives the multiplier registers.
- `rst`  in  1: reset, asynchronous, active-high.
- `clear`  in  1: synchronous flush of the FIFO and the statistics counters.
- `in_valid`  in  1: a new product is present on `in_result`/`in_overflow`.
- `in_result`  in  32: single-precision product.
- `in_overflow`  in  1: multiplier overflow flag for this product.
- `in_ready`  out  1: buffer can accept a product; equals not-full.
- `out_valid`  out  1: head entry available.
- `out_ready`  in  1: consumer accepts the head entry.
- `out_result`  out  32: head product.
- `out_overflow`  out  1: head overflow flag.
- `out_class`  out  3: head class code.
- `count`  out  $clog2(DEPTH)+1: current occupancy.
- `ovf_count`  out  CNT_W: number of accepted products with overflow set.
- `drop_count`  out  CNT_W: number of products offered while full.

## Operation
- Push: occurs when `in_valid && in_ready && !clear`. The stored entry is 36 bits: {class, overflow, result}. The class is computed at write time.
- Class codes:
  - 0 zero: exp=0, mant=0.
  - 1 subnormal: exp=0, mant≠0.
  - 2 normal.
  - 3 infinity: exp=FF, mant=0.
  - 4 NaN: exp=FF, mant≠0.
  - 5–7 are unused.
  - The sign bit is ignored for classification.
- Pop: occurs when `out_valid && out_ready && !clear`. The read pointer advances.
- FWFT behaviour: the `out_*` outputs show the entry at the read pointer whenever `out_valid`=1. While `out_valid`=0, `out_result`, `out_overflow` and `out_class` are forced to 0.
- `in_ready` = (`count` != DEPTH). It does not depend on `out_ready`, so a full buffer refuses a push even when a pop occurs in the same cycle.
- Push and pop in the same cycle with the buffer neither empty nor full: `count` is unchanged and both pointers advance.
- Pop request while empty: ignored, because `out_valid`=0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked by the `count` register, not by pointer comparison.
- `ovf_count`: increments on every push with `in_overflow`=1 and saturates at all-ones.
- `drop_count`: increments when `in_valid && !in_ready && !clear` and saturates at all-ones.
- `clear` has priority over push and pop in the same cycle:
  - Pointers, `count`, `ovf_count` and `drop_count` go to 0.
  - The product offered in that cycle is discarded and not counted as a drop.
- Storage contents are not reset; only the pointers and `count` define validity.

## Timing
- All state updates on `posedge slow_clk`. `rst` acts immediately.
- Reset values:
  - `count`=0, `out_valid`=0, `in_ready`=1.
  - `out_result`=0, `out_overflow`=0, `out_class`=0.
  - `ovf_count`=0, `drop_count`=0.
- Latency: a push at edge N gives `out_valid`=1 and valid head data after edge N, i.e. one cycle from input to output.
- A pop at edge N shows the next entry, or `out_valid`=0, after edge N.
- Assertion of `rst` mid-stream: all buffered entries are lost and outputs return to reset values asynchronously.
- `in_ready`, `out_valid` and `count` are derived combinationally from the registered `count` only, with no combinational path from `in_valid` or `out_ready`.

## Structure
- Shared package `fp_mul_pkg`:
  - field widths (`EXP_W`=8, `MANT_W`=23, `FP_W`=32);
  - `EXP_MAX`=8'hFF;
  - class code constants `FPC_ZERO`, `FPC_SUB`, `FPC_NORM`, `FPC_INF`, `FPC_NAN`.
- One combinational sub-module `fp_classify`: 32-bit input to 3-bit class output. It is instantiated on the write path.
- FIFO storage, pointers, `count` and the counters live in `fp_result_buffer` itself.

## Test plan
- Reset, then push 3F800000 (1.0, ovf=0), 7F800000 (ovf=1) and 00000001 while `out_ready`=0:
  - `count`=3, `ovf_count`=1;
  - head shows 3F800000 with class 2.
- Pop the entries in order:
  - `out_class` sequence is 2, 3, 1;
  - afterwards `out_valid`=0 and all `out_*`=0.
- Fill all 8 entries, then hold `in_valid`=1 for 2 more cycles with `out_ready`=0:
  - `in_ready`=0, `drop_count`=2, `count`=8.
- With the buffer full, assert `out_ready` and `in_valid` together:
  - one entry pops, no push occurs, `count`=7, `drop_count`=3.
- Stream 20 products with `in_valid`=`out_ready`=1 continuously:
  - output order matches input order across pointer wrap;
  - `count` stays at 0 or 1;
  - a product 7FC00000 appears with class 4.
- With 5 entries held, assert `clear` together with `in_valid`:
  - next cycle `count`=0, all counters 0, `drop_count` not incremented.
- With 5 entries held, assert `rst` mid-cycle:
  - outputs return to reset values immediately;
  - `in_ready`=1.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// Shared definitions for the sequential floating-point multiplier datapath:
// single-precision field widths, class codes and the buffered entry layout.
package fp_mul_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int FP_W   = 32;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    // Class codes 5..7 are never produced.
    typedef enum logic [2:0] {
        FPC_ZERO = 3'd0,
        FPC_SUB  = 3'd1,
        FPC_NORM = 3'd2,
        FPC_INF  = 3'd3,
        FPC_NAN  = 3'd4
    } fp_class_e;

    // Stored entry, 36 bits: {class, overflow, result}.
    typedef struct packed {
        logic [2:0]      cls;
        logic            ovf;
        logic [FP_W-1:0] result;
    } fp_entry_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 single-precision classifier; the sign bit does not
// influence the class.
module fp_classify
    import fp_mul_pkg::*;
(
    input  logic [FP_W-1:0] fp_in,
    output logic [2:0]      fp_class
);

    logic [EXP_W-1:0]  exp_field;
    logic [MANT_W-1:0] mant_field;
    logic              unused_sign;

    assign exp_field   = fp_in[FP_W-2 -: EXP_W];
    assign mant_field  = fp_in[MANT_W-1:0];
    assign unused_sign = fp_in[FP_W-1];

    always_comb begin
        fp_class = FPC_NORM;
        if (exp_field == '0) begin
            fp_class = (mant_field == '0) ? FPC_ZERO : FPC_SUB;
        end else if (exp_field == EXP_MAX) begin
            fp_class = (mant_field == '0) ? FPC_INF : FPC_NAN;
        end
    end

endmodule

// File: rtl/fp_result_buffer.sv
// First-word-fall-through buffer for multiplier products with per-entry class
// tagging and saturating overflow/drop statistics.
module fp_result_buffer
    import fp_mul_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     slow_clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic [31:0]              in_result,
    input  logic                     in_overflow,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_result,
    output logic                     out_overflow,
    output logic [2:0]               out_class,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         ovf_count,
    output logic [CNT_W-1:0]         drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [CNT_W-1:0] ovf_count_q, ovf_count_d;
    logic [CNT_W-1:0] drop_count_q, drop_count_d;

    fp_entry_t mem_q [DEPTH];
    fp_entry_t wr_entry;
    fp_entry_t head_entry;
    logic [2:0] in_class;

    logic push;
    logic pop;
    logic drop;

    fp_classify u_classify (
        .fp_in    (in_result),
        .fp_class (in_class)
    );

    // Flow control comes from the registered occupancy only, so a full buffer
    // refuses a push even when the head is popped in the same cycle.
    assign in_ready  = (count_q != FULL_COUNT);
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    assign push = in_valid && in_ready && !clear;
    assign pop  = out_valid && out_ready && !clear;
    assign drop = in_valid && !in_ready && !clear;

    assign wr_entry.cls    = in_class;
    assign wr_entry.ovf    = in_overflow;
    assign wr_entry.result = in_result;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        ovf_count_d  = ovf_count_q;
        drop_count_d = drop_count_q;

        if (clear) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            ovf_count_d  = '0;
            drop_count_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (push && in_overflow && (ovf_count_q != '1)) begin
                ovf_count_d = ovf_count_q + 1'b1;
            end
            if (drop && (drop_count_q != '1)) begin
                drop_count_d = drop_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ovf_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ovf_count_q  <= ovf_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Storage is deliberately left out of reset; pointers and count define validity.
    always_ff @(posedge slow_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign head_entry = mem_q[rd_ptr_q];

    assign out_result   = out_valid ? head_entry.result : '0;
    assign out_overflow = out_valid ? head_entry.ovf    : 1'b0;
    assign out_class    = out_valid ? head_entry.cls    : 3'd0;
    assign ovf_count    = ovf_count_q;
    assign drop_count   = drop_count_q;

endmodule

// File: tb/tb_fp_result_buffer.sv
// Self-checking bench for fp_result_buffer: directed scenarios plus a random
// run against a queue-based reference model.
module tb_fp_result_buffer;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    logic        slow_clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic [31:0] in_result;
    logic        in_overflow;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic [2:0]  out_class;
    logic [3:0]  count;
    logic [15:0] ovf_count;
    logic [15:0] drop_count;

    int errors = 0;
    int checks = 0;

    // Reference model: queue of {overflow, result}, plus two counters.
    logic [32:0] mq[$];
    int          m_ovf;
    int          m_drop;

    fp_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .slow_clk     (slow_clk),
        .rst          (rst),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_result    (in_result),
        .in_overflow  (in_overflow),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_overflow (out_overflow),
        .out_class    (out_class),
        .count        (count),
        .ovf_count    (ovf_count),
        .drop_count   (drop_count)
    );

    always #5 slow_clk = ~slow_clk;

    function automatic int cls_of(logic [31:0] x);
        int e;
        int m;
        e = int'((x >> 23) & 32'hFF);
        m = int'(x & 32'h7FFFFF);
        if (e == 0)   return (m == 0) ? 0 : 1;
        if (e == 255) return (m == 0) ? 3 : 4;
        return 2;
    endfunction

    // Advance the model by one clock using the current inputs, then step
    // the DUT and land 1 time unit after the edge.
    task automatic tick();
        bit full;
        full = (mq.size() == DEPTH);
        if (clear) begin
            if (mq.size() != 0) $display("clear  flushed=%0d", mq.size());
            mq.delete();
            m_ovf  = 0;
            m_drop = 0;
        end else begin
            if (out_ready && mq.size() > 0) begin
                $display("pop    result=%08h ovf=%0d class=%0d", mq[0][31:0], mq[0][32], cls_of(mq[0][31:0]));
                void'(mq.pop_front());
            end
            if (in_valid && !full) begin
                mq.push_back({in_overflow, in_result});
                if (in_overflow && m_ovf < 65535) m_ovf++;
                $display("push   result=%08h ovf=%0d", in_result, in_overflow);
            end else if (in_valid) begin
                if (m_drop < 65535) m_drop++;
                $display("drop   result=%08h", in_result);
            end
        end
        @(posedge slow_clk);
        #1;
    endtask

    function automatic logic [31:0] rand_fp();
        case ($urandom_range(0, 9))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'h0000_0001;
            3: return 32'h807F_FFFF;
            4: return 32'h3F80_0000;
            5: return 32'h7F80_0000;
            6: return 32'hFF80_0000;
            7: return 32'h7FC0_0000;
            8: return 32'hFF80_0001;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_result = '0; in_overflow = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge slow_clk);
        #1;
        checks++; if (count !== 4'd0)        begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (out_valid !== 1'b0)    begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1)     begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        checks++; if (out_result !== 32'h0)  begin errors++; $display("FAIL reset_out_result: got %08h want 0", out_result); end
        checks++; if (out_class !== 3'd0)    begin errors++; $display("FAIL reset_out_class: got %0d want 0", out_class); end
        checks++; if (ovf_count !== 16'd0 || drop_count !== 16'd0) begin errors++; $display("FAIL reset_counters: got ovf=%0d drop=%0d want 0 0", ovf_count, drop_count); end
        #3 rst = 1'b0;
        mq.delete(); m_ovf = 0; m_drop = 0;
        @(posedge slow_clk);
        #1;
    endtask

    task automatic test_fill_pop();
        logic [31:0] vals [3];
        logic        ovfs [3];
        int          cls_exp [3];
        vals = '{32'h3F80_0000, 32'h7F80_0000, 32'h0000_0001};
        ovfs = '{1'b0, 1'b1, 1'b0};
        cls_exp = '{2, 3, 1};
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_result = vals[i]; in_overflow = ovfs[i];
            tick();
        end
        in_valid = 1'b0;
        checks++; if (count !== 4'd3)               begin errors++; $display("FAIL fill_count: got %0d want 3", count); end
        checks++; if (ovf_count !== 16'd1)          begin errors++; $display("FAIL fill_ovf_count: got %0d want 1", ovf_count); end
        checks++; if (out_result !== 32'h3F80_0000) begin errors++; $display("FAIL fill_head: got %08h want 3f800000", out_result); end
        checks++; if (out_class !== 3'd2)           begin errors++; $display("FAIL fill_head_class: got %0d want 2", out_class); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b1 || out_result !== vals[i] || out_overflow !== ovfs[i] || out_class !== 3'(cls_exp[i]))
                begin errors++; $display("FAIL pop_seq[%0d]: got v=%0b %08h ovf=%0b cls=%0d want 1 %08h %0b %0d", i, out_valid, out_result, out_overflow, out_class, vals[i], ovfs[i], cls_exp[i]); end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || out_result !== 32'h0 || out_overflow !== 1'b0 || out_class !== 3'd0 || count !== 4'd0)
            begin errors++; $display("FAIL empty_outputs: got v=%0b %08h ovf=%0b cls=%0d cnt=%0d want all 0", out_valid, out_result, out_overflow, out_class, count); end
    endtask

    task automatic test_full_drop();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            in_valid = 1'b1; in_result = $urandom; in_overflow = 1'($urandom_range(0, 1));
            tick();
        end
        checks++; if (in_ready !== 1'b0)       begin errors++; $display("FAIL full_in_ready: got %0b want 0", in_ready); end
        checks++; if (drop_count !== 16'd2)    begin errors++; $display("FAIL full_drop_count: got %0d want 2", drop_count); end
        checks++; if (count !== 4'd8)          begin errors++; $display("FAIL full_count: got %0d want 8", count); end
        checks++; if (ovf_count !== 16'(m_ovf)) begin errors++; $display("FAIL full_ovf_count: got %0d want %0d", ovf_count, m_ovf); end
    endtask

    task automatic test_full_pop();
        in_valid = 1'b1; in_result = $urandom; in_overflow = 1'b0; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (count !== 4'd7)        begin errors++; $display("FAIL fullpop_count: got %0d want 7", count); end
        checks++; if (drop_count !== 16'd3)  begin errors++; $display("FAIL fullpop_drop_count: got %0d want 3", drop_count); end
        for (int n = 0; n < 2 * DEPTH && mq.size() > 0; n++) begin
            checks++; if (out_result !== mq[0][31:0] || out_overflow !== mq[0][32])
                begin errors++; $display("FAIL drain_head: got %08h ovf=%0b want %08h ovf=%0b", out_result, out_overflow, mq[0][31:0], mq[0][32]); end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got out_valid=%0b want 0", out_valid); end
    endtask

    task automatic test_stream();
        logic [31:0] sent;
        bit          seen_nan;
        seen_nan = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1; in_overflow = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sent = (i == 7) ? 32'h7FC0_0000 : $urandom;
            in_result = sent;
            tick();
            checks++; if (count > 4'd1) begin errors++; $display("FAIL stream_count[%0d]: got %0d want <=1", i, count); end
            checks++; if (out_valid !== 1'b1 || out_result !== sent)
                begin errors++; $display("FAIL stream_order[%0d]: got v=%0b %08h want 1 %08h", i, out_valid, out_result, sent); end
            if (sent == 32'h7FC0_0000) begin
                seen_nan = 1'b1;
                checks++; if (out_class !== 3'd4) begin errors++; $display("FAIL stream_nan_class: got %0d want 4", out_class); end
            end
        end
        checks++; if (!seen_nan) begin errors++; $display("FAIL stream_nan_seen: got 0 want 1"); end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] exp_res;
        for (int i = 0; i < 400; i++) begin
            clear       = ($urandom_range(0, 39) == 0);
            in_valid    = 1'($urandom_range(0, 3) != 0);
            out_ready   = 1'($urandom_range(0, 2) == 0);
            in_result   = rand_fp();
            in_overflow = 1'($urandom_range(0, 1));
            tick();
            exp_res = (mq.size() > 0) ? mq[0][31:0] : 32'h0;
            checks++; if (count !== 4'(mq.size()) || in_ready !== (mq.size() != DEPTH) || out_valid !== (mq.size() != 0))
                begin errors++; $display("FAIL rand_occupancy[%0d]: got cnt=%0d rdy=%0b v=%0b want cnt=%0d", i, count, in_ready, out_valid, mq.size()); end
            checks++; if (out_result !== exp_res || out_overflow !== ((mq.size() > 0) ? mq[0][32] : 1'b0) ||
                          out_class !== ((mq.size() > 0) ? 3'(cls_of(exp_res)) : 3'd0))
                begin errors++; $display("FAIL rand_head[%0d]: got %08h ovf=%0b cls=%0d want %08h cls=%0d", i, out_result, out_overflow, out_class, exp_res, cls_of(exp_res)); end
            checks++; if (ovf_count !== 16'(m_ovf) || drop_count !== 16'(m_drop))
                begin errors++; $display("FAIL rand_counters[%0d]: got ovf=%0d drop=%0d want %0d %0d", i, ovf_count, drop_count, m_ovf, m_drop); end
        end
        clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_clear();
        clear = 1'b1; tick(); clear = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_result = rand_fp(); in_overflow = 1'b1;
            tick();
        end
        checks++; if (count !== 4'd5 || ovf_count !== 16'd5) begin errors++; $display("FAIL clear_setup: got cnt=%0d ovf=%0d want 5 5", count, ovf_count); end
        clear = 1'b1; in_valid = 1'b1;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        checks++; if (count !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL clear_flush: got cnt=%0d v=%0b rdy=%0b want 0 0 1", count, out_valid, in_ready); end
        checks++; if (ovf_count !== 16'd0 || drop_count !== 16'd0)
            begin errors++; $display("FAIL clear_counters: got ovf=%0d drop=%0d want 0 0", ovf_count, drop_count); end
        // Clearing a full buffer while a product is offered must not count a drop.
        for (int i = 0; i < DEPTH + 1; i++) begin
            in_valid = 1'b1; in_result = rand_fp(); in_overflow = 1'b0;
            tick();
        end
        clear = 1'b1;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        tick();
        checks++; if (drop_count !== 16'd0 || count !== 4'd0)
            begin errors++; $display("FAIL clear_full_drop: got drop=%0d cnt=%0d want 0 0", drop_count, count); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_result = 32'h4000_0000 + 32'(i); in_overflow = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        checks++; if (count !== 4'd5 || ovf_count !== 16'd5) begin errors++; $display("FAIL arst_setup: got cnt=%0d ovf=%0d want 5 5", count, ovf_count); end
        #2 rst = 1'b1;
        #1;
        checks++; if (count !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL arst_flow: got cnt=%0d v=%0b rdy=%0b want 0 0 1", count, out_valid, in_ready); end
        checks++; if (out_result !== 32'h0 || out_overflow !== 1'b0 || out_class !== 3'd0 || ovf_count !== 16'd0 || drop_count !== 16'd0)
            begin errors++; $display("FAIL arst_outputs: got %08h ovf=%0b cls=%0d oc=%0d dc=%0d want all 0", out_result, out_overflow, out_class, ovf_count, drop_count); end
        mq.delete(); m_ovf = 0; m_drop = 0;
        @(posedge slow_clk);
        #1 rst = 1'b0;
        tick();
        checks++; if (count !== 4'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL arst_after: got cnt=%0d v=%0b want 0 0", count, out_valid); end
    endtask

    initial begin
        test_reset();
        test_fill_pop();
        test_full_drop();
        test_full_pop();
        test_stream();
        test_random();
        test_clear();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
